// File: rtl/ddd_pace_controller.sv
// ddd_pace_controller
// Dual-chamber (DDD) pacing timing controller. Synchronises the atrial and
// ventricular sense inputs, runs the AEI/AVI escape cycle against a 1 ms tick,
// enforces the PVARP/VRP refractory windows and the upper rate interval, and
// emits fixed-width AP/VP pace pulses plus accepted-sense strobes.
module ddd_pace_controller #(
    parameter int CLK_PER_MS   = 50000,
    parameter int AVI_MS       = 150,
    parameter int AEI_MS       = 850,
    parameter int PVARP_MS     = 50,
    parameter int VRP_MS       = 150,
    parameter int URI_MS       = 400,
    parameter int PULSE_CYCLES = 8,
    parameter int TW           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       AS,
    input  logic       VS,
    output logic       AP,
    output logic       VP,
    output logic       as_evt,
    output logic       vs_evt,
    output logic [1:0] state
);

    localparam int PW = $clog2(CLK_PER_MS);
    localparam int CW = $clog2(PULSE_CYCLES + 1);

    localparam logic [TW-1:0] AVI_T   = TW'(AVI_MS);
    localparam logic [TW-1:0] AEI_T   = TW'(AEI_MS);
    localparam logic [TW-1:0] PVARP_T = TW'(PVARP_MS);
    localparam logic [TW-1:0] VRP_T   = TW'(VRP_MS);
    localparam logic [TW-1:0] URI_T   = TW'(URI_MS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_VA     = 2'd0,
        ST_AV     = 2'd1,
        ST_AV_URI = 2'd2
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic [2:0]    as_sync;
    logic [2:0]    vs_sync;
    logic          as_r;
    logic          vs_r;
    logic [PW-1:0] presc;
    logic          ms_tick;
    logic [TW-1:0] aei_t;
    logic [TW-1:0] avi_t;
    logic [TW-1:0] pvarp_t;
    logic [TW-1:0] vrp_t;
    logic [TW-1:0] uri_t;
    logic          v_seen;
    logic          aei_exp;
    logic          avi_exp;
    logic          pvarp_exp;
    logic          vrp_exp;
    logic          uri_exp;
    logic          acc_as;
    logic          acc_vs;
    logic          fire_ap;
    logic          fire_vp;
    logic          a_event;
    logic          v_event;
    logic [CW-1:0] ap_cnt;
    logic [CW-1:0] vp_cnt;

    assign state = cur_state;

    // Two-flop synchronisers plus a history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            as_sync <= '0;
            vs_sync <= '0;
        end else begin
            as_sync <= {as_sync[1:0], AS};
            vs_sync <= {vs_sync[1:0], VS};
        end
    end

    assign as_r = as_sync[1] & ~as_sync[2];
    assign vs_r = vs_sync[1] & ~vs_sync[2];

    // Prescaler producing one ms_tick per millisecond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (presc == PRESC_LAST)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    assign ms_tick = (presc == PRESC_LAST);

    // Until the first V event there is no refractory window and URI is satisfied.
    assign aei_exp   = (aei_t == AEI_T);
    assign avi_exp   = (avi_t == AVI_T);
    assign pvarp_exp = !v_seen || (pvarp_t == PVARP_T);
    assign vrp_exp   = !v_seen || (vrp_t == VRP_T);
    assign uri_exp   = !v_seen || (uri_t == URI_T);

    assign a_event = acc_as | fire_ap;
    assign v_event = acc_vs | fire_vp;

    // Interval timers: clear on their start event, otherwise count ms and saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aei_t   <= '0;
            avi_t   <= '0;
            pvarp_t <= '0;
            vrp_t   <= '0;
            uri_t   <= '0;
            v_seen  <= 1'b0;
        end else begin
            if (v_event) begin
                aei_t   <= '0;
                pvarp_t <= '0;
                vrp_t   <= '0;
                uri_t   <= '0;
                v_seen  <= 1'b1;
            end else if (ms_tick) begin
                if (aei_t != AEI_T)     aei_t   <= aei_t + TW'(1);
                if (pvarp_t != PVARP_T) pvarp_t <= pvarp_t + TW'(1);
                if (vrp_t != VRP_T)     vrp_t   <= vrp_t + TW'(1);
                if (uri_t != URI_T)     uri_t   <= uri_t + TW'(1);
            end
            if (a_event)
                avi_t <= '0;
            else if (ms_tick && avi_t != AVI_T)
                avi_t <= avi_t + TW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cur_state <= ST_VA;
        else
            cur_state <= nxt_state;
    end

    // Decide which sense is accepted and which pace fires; senses beat paces, VS beats AS.
    always_comb begin
        acc_as  = 1'b0;
        acc_vs  = 1'b0;
        fire_ap = 1'b0;
        fire_vp = 1'b0;
        case (cur_state)
            ST_VA: begin
                if (vs_r && vrp_exp)        acc_vs  = 1'b1;
                else if (as_r && pvarp_exp) acc_as  = 1'b1;
                else if (aei_exp)           fire_ap = 1'b1;
            end
            ST_AV: begin
                if (vs_r && vrp_exp)        acc_vs  = 1'b1;
                else if (avi_exp && uri_exp) fire_vp = 1'b1;
            end
            ST_AV_URI: begin
                if (vs_r && vrp_exp)        acc_vs  = 1'b1;
                else if (uri_exp)           fire_vp = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state logic driven by the accepted events.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_VA: begin
                if (acc_as || fire_ap) nxt_state = ST_AV;
            end
            ST_AV: begin
                if (acc_vs || fire_vp) nxt_state = ST_VA;
                else if (avi_exp)      nxt_state = ST_AV_URI;
            end
            ST_AV_URI: begin
                if (acc_vs || fire_vp) nxt_state = ST_VA;
            end
            default: nxt_state = ST_VA;
        endcase
    end

    // Registered strobes and fixed-width pace pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            as_evt <= 1'b0;
            vs_evt <= 1'b0;
            AP     <= 1'b0;
            VP     <= 1'b0;
            ap_cnt <= '0;
            vp_cnt <= '0;
        end else begin
            as_evt <= acc_as;
            vs_evt <= acc_vs;
            if (fire_ap) begin
                AP     <= 1'b1;
                ap_cnt <= PULSE_LAST;
            end else if (ap_cnt != '0) begin
                ap_cnt <= ap_cnt - CW'(1);
            end else begin
                AP <= 1'b0;
            end
            if (fire_vp) begin
                VP     <= 1'b1;
                vp_cnt <= PULSE_LAST;
            end else if (vp_cnt != '0) begin
                vp_cnt <= vp_cnt - CW'(1);
            end else begin
                VP <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ddd_pace_controller.sv
// tb_ddd_pace_controller
// Directed bench for the DDD pacing controller with a 4-clock millisecond.
// Edge n after reset release is counted in cyc; an event at T ms corresponds to
// the pace rising at edge 4*T+1, and a sense driven after edge 4*T is accepted
// at edge 4*T+3.
module tb_ddd_pace_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       AS;
    logic       VS;
    logic       AP;
    logic       VP;
    logic       as_evt;
    logic       vs_evt;
    logic [1:0] state;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int ap_rises, ap_last, ap_width, ap_run;
    int vp_rises, vp_last, vp_width, vp_run;
    int as_cnt, as_last, vs_cnt, vs_last;
    logic ap_q, vp_q;

    ddd_pace_controller #(.CLK_PER_MS(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .AS     (AS),
        .VS     (VS),
        .AP     (AP),
        .VP     (VP),
        .as_evt (as_evt),
        .vs_evt (vs_evt),
        .state  (state)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Count active edges since reset release.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Record pulse rises, widths and strobe occurrences on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            ap_rises = 0; ap_last = -1; ap_width = 0; ap_run = 0; ap_q = 1'b0;
            vp_rises = 0; vp_last = -1; vp_width = 0; vp_run = 0; vp_q = 1'b0;
            as_cnt = 0; as_last = -1; vs_cnt = 0; vs_last = -1;
        end else begin
            if (AP && !ap_q) begin ap_rises++; ap_last = cyc; ap_run = 0; end
            if (AP) ap_run++; else if (ap_q) ap_width = ap_run;
            ap_q = AP;
            if (VP && !vp_q) begin vp_rises++; vp_last = cyc; vp_run = 0; end
            if (VP) vp_run++; else if (vp_q) vp_width = vp_run;
            vp_q = VP;
            if (as_evt) begin as_cnt++; as_last = cyc; end
            if (vs_evt) begin vs_cnt++; vs_last = cyc; end
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic v);
        AS = a;
        VS = v;
    endtask

    task automatic waitCycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic senseAt(input int c, input logic a, input logic v);
        waitCycle(c);
        applyStimulus(a, v);
        waitCycle(c + 8);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_ap", int'(AP), 0);
        checkOutput("rst_vp", int'(VP), 0);
        checkOutput("rst_as_evt", int'(as_evt), 0);
        checkOutput("rst_vs_evt", int'(vs_evt), 0);
        checkOutput("rst_state", int'(state), 0);
        rst_n = 1'b1;

        $display("[TB] scenario 1: free running, no senses");
        waitCycle(3405);
        checkOutput("t1_ap1_rises", ap_rises, 1);
        checkOutput("t1_ap1_time", ap_last, 3401);
        checkOutput("t1_state_av", int'(state), 1);
        waitCycle(4010);
        checkOutput("t1_vp1_time", vp_last, 4001);
        checkOutput("t1_ap_width", ap_width, 8);
        checkOutput("t1_state_va", int'(state), 0);
        waitCycle(8020);
        checkOutput("t1_ap_rises", ap_rises, 2);
        checkOutput("t1_ap2_time", ap_last, 7401);
        checkOutput("t1_vp_rises", vp_rises, 2);
        checkOutput("t1_vp2_time", vp_last, 8001);
        checkOutput("t1_vp_width", vp_width, 8);

        $display("[TB] scenario 2: AS at 1300 ms");
        doReset();
        senseAt(5200, 1'b1, 1'b0);
        waitCycle(5210);
        checkOutput("t2_as_cnt", as_cnt, 1);
        checkOutput("t2_as_time", as_last, 5203);
        checkOutput("t2_state", int'(state), 1);
        waitCycle(7500);
        checkOutput("t2_vp_time", vp_last, 5801);
        checkOutput("t2_vp_rises", vp_rises, 2);
        checkOutput("t2_ap_rises", ap_rises, 1);

        $display("[TB] scenario 3a: AS at 1100 ms, VP held off by URI");
        doReset();
        senseAt(4400, 1'b1, 1'b0);
        waitCycle(5010);
        checkOutput("t3a_state_uri", int'(state), 2);
        checkOutput("t3a_vp_rises_hold", vp_rises, 1);
        waitCycle(5610);
        checkOutput("t3a_vp_rises", vp_rises, 2);
        checkOutput("t3a_vp_time", vp_last, 5601);
        checkOutput("t3a_state_va", int'(state), 0);

        $display("[TB] scenario 3b: AS at 1100 ms then VS at 1300 ms");
        doReset();
        senseAt(4400, 1'b1, 1'b0);
        senseAt(5200, 1'b0, 1'b1);
        waitCycle(5210);
        checkOutput("t3b_vs_cnt", vs_cnt, 1);
        checkOutput("t3b_vs_time", vs_last, 5203);
        checkOutput("t3b_state", int'(state), 0);
        waitCycle(5700);
        checkOutput("t3b_vp_rises", vp_rises, 1);

        $display("[TB] scenario 4: senses inside PVARP and VRP");
        doReset();
        senseAt(4120, 1'b1, 1'b0);
        senseAt(4400, 1'b0, 1'b1);
        waitCycle(7420);
        checkOutput("t4_as_cnt", as_cnt, 0);
        checkOutput("t4_vs_cnt", vs_cnt, 0);
        checkOutput("t4_ap_rises", ap_rises, 2);
        checkOutput("t4_ap_time", ap_last, 7401);
        checkOutput("t4_state", int'(state), 1);

        $display("[TB] scenario 5: VS at 1500 ms restarts AEI");
        doReset();
        senseAt(6000, 1'b0, 1'b1);
        waitCycle(6010);
        checkOutput("t5_vs_time", vs_last, 6003);
        waitCycle(10020);
        checkOutput("t5_ap_rises", ap_rises, 2);
        checkOutput("t5_ap_time", ap_last, 9401);
        checkOutput("t5_vp_rises", vp_rises, 2);
        checkOutput("t5_vp_time", vp_last, 10001);

        $display("[TB] scenario 6: reset mid-VP, then AS and VS together");
        doReset();
        waitCycle(4003);
        checkOutput("t6_vp_before_rst", int'(VP), 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_vp_async_drop", int'(VP), 0);
        checkOutput("t6_state_rst", int'(state), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        waitCycle(3405);
        checkOutput("t6_ap_after_release", ap_last, 3401);
        senseAt(5200, 1'b1, 1'b1);
        waitCycle(5210);
        checkOutput("t6_vs_cnt", vs_cnt, 1);
        checkOutput("t6_vs_time", vs_last, 5203);
        checkOutput("t6_as_cnt", as_cnt, 0);
        checkOutput("t6_state", int'(state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
